// File: rtl/pcs_pkg.sv
// pcs_pkg: shared constants and types for the 64b/66b transmit encoder.
// Block types, XGMII characters, control codes, FSM and class enums.
package pcs_pkg;

  localparam logic [7:0] XG_IDLE  = 8'h07;
  localparam logic [7:0] XG_START = 8'hFB;
  localparam logic [7:0] XG_TERM  = 8'hFD;
  localparam logic [7:0] XG_ERROR = 8'hFE;
  localparam logic [7:0] XG_SEQ   = 8'h9C;

  localparam logic [7:0] BLOCK_TYPE_C   = 8'h1E;
  localparam logic [7:0] BLOCK_TYPE_S0  = 8'h78;
  localparam logic [7:0] BLOCK_TYPE_S4  = 8'h33;
  localparam logic [7:0] BLOCK_TYPE_OS0 = 8'h4B;
  localparam logic [7:0] BLOCK_TYPE_OS4 = 8'h2D;

  localparam logic [6:0] CTRL_IDLE = 7'h00;
  localparam logic [6:0] CTRL_ERR  = 7'h1E;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [63:0] ERR_BLOCK =
    {{8{CTRL_ERR}}, BLOCK_TYPE_C};

  typedef enum logic [2:0] {
    TX_INIT, TX_C, TX_D, TX_T, TX_E
  } tx_state_e;

  typedef enum logic [2:0] {
    CLS_C, CLS_S, CLS_D, CLS_T, CLS_E
  } blk_class_e;

  // Mask of lanes strictly below lane k (k = 0..8).
  function automatic logic [7:0] lo_mask(input int k);
    logic [15:0] m;
    m = (16'h1 << k) - 16'h1;
    return m[7:0];
  endfunction

  // Terminate block type for /T/ in lane n.
  function automatic logic [7:0] t_type(input int n);
    unique case (n)
      0: return 8'h87;
      1: return 8'h99;
      2: return 8'hAA;
      3: return 8'hB4;
      4: return 8'hCC;
      5: return 8'hD2;
      6: return 8'hE1;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/pcs_enc_classify.sv
// pcs_enc_classify: combinational block classifier and encoder.
// Ordered-set classes are built only with PCS_ENC_OS_EN defined.
module pcs_enc_classify
  import pcs_pkg::*;
(
  input  logic [63:0] blk_d,
  input  logic [7:0]  blk_c,
  output blk_class_e  cls,
  output logic [63:0] enc
);

  logic [7:0]  is_idle;
  logic [7:0]  is_err;
  logic [55:0] c_codes;
  logic        all_c;
  logic        is_s0;
  logic        is_s4;
  logic        is_d;
  logic        is_t;
  logic [63:0] t_enc;

  // Per-lane idle/error detection and 7-bit control codes.
  always_comb begin
    is_idle = '0;
    is_err  = '0;
    c_codes = '0;
    for (int i = 0; i < 8; i++) begin
      is_idle[i] = blk_c[i] &&
                   (blk_d[i*8 +: 8] == XG_IDLE);
      is_err[i]  = blk_c[i] &&
                   (blk_d[i*8 +: 8] == XG_ERROR);
      c_codes[i*7 +: 7] =
        is_err[i] ? CTRL_ERR : CTRL_IDLE;
    end
  end

  assign all_c = &(is_idle | is_err);
  assign is_s0 = (blk_c == 8'h01) &&
                 (blk_d[7:0] == XG_START);
  assign is_s4 = (blk_c == 8'h1F) &&
                 (&is_idle[3:0]) &&
                 (blk_d[39:32] == XG_START);
  assign is_d  = (blk_c == 8'h00);

`ifdef PCS_ENC_OS_EN
  logic is_os0;
  logic is_os4;
  assign is_os0 = (blk_c == 8'hF1) &&
                  (blk_d[7:0] == XG_SEQ) &&
                  (&is_idle[7:4]);
  assign is_os4 = (blk_c == 8'h1F) &&
                  (&is_idle[3:0]) &&
                  (blk_d[39:32] == XG_SEQ);
`endif

  // Terminate detection: data below /T/, idle above it.
  always_comb begin
    is_t  = 1'b0;
    t_enc = '0;
    for (int n = 0; n < 8; n++) begin
      if (blk_c[n] &&
          (blk_d[n*8 +: 8] == XG_TERM) &&
          ((blk_c & lo_mask(n)) == 8'h00) &&
          ((is_idle | lo_mask(n + 1)) == 8'hFF)) begin
        is_t       = 1'b1;
        t_enc      = '0;
        t_enc[7:0] = t_type(n);
        for (int k = 0; k < 7; k++)
          if (k < n)
            t_enc[k*8+8 +: 8] = blk_d[k*8 +: 8];
      end
    end
  end

  // Class select and encoded payload.
  always_comb begin
    cls = CLS_E;
    enc = ERR_BLOCK;
    unique case (1'b1)
      all_c: begin
        cls = CLS_C;
        enc = {c_codes, BLOCK_TYPE_C};
      end
      is_s0: begin
        cls = CLS_S;
        enc = {blk_d[63:8], BLOCK_TYPE_S0};
      end
      is_s4: begin
        cls = CLS_S;
        enc = {blk_d[63:40], 4'h0,
               c_codes[27:0], BLOCK_TYPE_S4};
      end
      is_d: begin
        cls = CLS_D;
        enc = blk_d;
      end
      is_t: begin
        cls = CLS_T;
        enc = t_enc;
      end
`ifdef PCS_ENC_OS_EN
      is_os0: begin
        cls = CLS_C;
        enc = {c_codes[55:28], 4'h0,
               blk_d[31:8], BLOCK_TYPE_OS0};
      end
      is_os4: begin
        cls = CLS_C;
        enc = {blk_d[63:40], 4'h0,
               c_codes[27:0], BLOCK_TYPE_OS4};
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/pcs_enc_fsm.sv
// pcs_enc_fsm: 64b/66b transmit encoder, assembly, FSM, slicing.
// Define PCS_ENC_OS_EN to add ordered-set block classes.
module pcs_enc_fsm
  import pcs_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int BLOCK_W = 64,
  parameter int CNT_N   = BLOCK_W / DATA_W,
  parameter int KEEP_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [KEEP_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic              head_v_o,
  output logic [1:0]        sync_head_o,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o
);

  localparam int CNT_W = (CNT_N > 1) ? $clog2(CNT_N) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_N - 1);

  logic [CNT_W-1:0] cnt;
  logic [63:0]      asm_d;
  logic [7:0]       asm_c;
  logic [63:0]      blk_d;
  logic [7:0]       blk_c;
  logic [63:0]      hold;
  logic             blk_done;
  blk_class_e       cls;
  logic [63:0]      enc;
  tx_state_e        state;
  tx_state_e        next_state;
  logic [63:0]      out_blk;
  logic [1:0]       out_sync;
  logic             out_err;

  assign blk_done = valid_i && (cnt == CNT_MAX);

  // Current beat merged into the partial block.
  always_comb begin
    blk_d = asm_d;
    blk_c = asm_c;
    blk_d[int'(cnt)*DATA_W +: DATA_W] = data_i;
    blk_c[int'(cnt)*KEEP_W +: KEEP_W] = ctrl_i;
  end

  pcs_enc_classify u_cls (
    .blk_d (blk_d),
    .blk_c (blk_c),
    .cls   (cls),
    .enc   (enc)
  );

  // Part counter and assembly buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      asm_d <= '0;
      asm_c <= '0;
    end else if (valid_i) begin
      cnt   <= blk_done ? '0 : cnt + CNT_W'(1);
      asm_d <= blk_d;
      asm_c <= blk_c;
    end
  end

  // Transmit state register, steps per complete block.
  always_ff @(posedge clk) begin
    if (reset)
      state <= TX_INIT;
    else if (blk_done)
      state <= next_state;
  end

  // Transmit next-state logic.
  always_comb begin
    next_state = TX_E;
    unique case (state)
      TX_D: begin
        if (cls == CLS_D)
          next_state = TX_D;
        else if (cls == CLS_T)
          next_state = TX_T;
      end
      TX_E: begin
        unique case (cls)
          CLS_C:   next_state = TX_C;
          CLS_S:   next_state = TX_D;
          CLS_D:   next_state = TX_D;
          CLS_T:   next_state = TX_T;
          default: next_state = TX_E;
        endcase
      end
      default: begin
        if (cls == CLS_C)
          next_state = TX_C;
        else if (cls == CLS_S)
          next_state = TX_D;
      end
    endcase
  end

  // Block to emit: encoded payload or error block.
  always_comb begin
    out_blk  = enc;
    out_sync = (cls == CLS_D) ? SYNC_DATA : SYNC_CTRL;
    out_err  = 1'b0;
    if (next_state == TX_E) begin
      out_blk  = ERR_BLOCK;
      out_sync = SYNC_CTRL;
      out_err  = 1'b1;
    end
  end

  // Slice 0 leaves on completion; the rest ride later beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_o     <= 1'b0;
      head_v_o    <= 1'b0;
      sync_head_o <= SYNC_CTRL;
      data_o      <= '0;
      err_o       <= 1'b0;
      hold        <= '0;
    end else begin
      valid_o  <= valid_i;
      head_v_o <= 1'b0;
      err_o    <= 1'b0;
      if (blk_done) begin
        hold        <= out_blk;
        data_o      <= out_blk[DATA_W-1:0];
        head_v_o    <= 1'b1;
        sync_head_o <= out_sync;
        err_o       <= out_err;
      end else if (valid_i) begin
        data_o <= hold[((int'(cnt) + 1) % CNT_N)
                       * DATA_W +: DATA_W];
      end
    end
  end

endmodule
